// File: rtl/core_dma_pkg.sv
// core_dma_pkg: shared beat size, response metadata record and keep-mask helper for the core DMA read path.
package core_dma_pkg;
  localparam int BEAT_BYTES = 16;
  typedef struct packed {
    logic [3:0]  first_off;
    logic [3:0]  end_off;
    logic [12:0] beats;
  } meta_t;
  function automatic logic [15:0] keep_mask(input logic first, input logic last,
                                            input logic [3:0] first_off, input logic [3:0] end_off);
    logic [15:0] lo_m, hi_m;
    lo_m = first ? 16'hFFFF << first_off : 16'hFFFF;
    hi_m = (last && end_off != 4'd0) ? ~(16'hFFFF << end_off) : 16'hFFFF;
    return lo_m & hi_m;
  endfunction
endpackage

// File: rtl/simple_fifo.sv
// simple_fifo: first-word-fall-through FIFO, power-of-2 depth; pushes when full and pops when empty are ignored.
module simple_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign do_push = push_i && !full_o;
  assign do_pop = pop_i && !empty_o;
  assign dout_o = mem_q[rd_q];
  assign full_o = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= do_push ? wr_q + 1'b1 : wr_q;
      rd_q <= do_pop ? rd_q + 1'b1 : rd_q;
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end
endmodule

// File: rtl/core_dma_rd_initiator.sv
// core_dma_rd_initiator: turns byte-granular reads into 16-byte beat commands and frames the responses with keep/last.
// Optional statistics counters are built when CORE_DMA_RD_STATS_EN is defined.
module core_dma_rd_initiator
  import core_dma_pkg::*;
#(
  parameter int DATA_WIDTH      = 128,
  parameter int ADDR_WIDTH      = 26,
  parameter int LEN_WIDTH       = 16,
  parameter int MAX_OUTSTANDING = 32,
  parameter int META_DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LEN_WIDTH-1:0]  req_len,
  input  logic                  req_valid,
  output logic                  req_ready,
  output logic                  dma_cmd_rd_en,
  output logic [ADDR_WIDTH-1:0] dma_cmd_rd_addr,
  output logic                  dma_cmd_rd_last,
  input  logic                  dma_cmd_rd_ready,
  input  logic                  dma_rd_resp_valid,
  output logic                  dma_rd_resp_ready,
  input  logic [DATA_WIDTH-1:0] dma_rd_resp_data,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic [15:0]           m_tkeep,
  output logic                  m_tlast,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [31:0]           stat_req_count,
  output logic [31:0]           stat_beat_count
);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  typedef enum logic {IDLE, ISSUE} state_e;
  state_e state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [12:0] left_q, left_d, rcnt_q, beats;
  logic [OW-1:0] os_q;
  logic [LEN_WIDTH:0] span;
  meta_t entry, head;
  logic fifo_full, fifo_empty, req_fire, cmd_fire, resp_fire, head_last;
  assign span = (LEN_WIDTH+1)'(req_addr[3:0]) + {1'b0, req_len} + (LEN_WIDTH+1)'(BEAT_BYTES - 1);
  assign beats = 13'(span[LEN_WIDTH:4]);
  assign entry = '{first_off: req_addr[3:0], end_off: req_addr[3:0] + req_len[3:0], beats: beats};
  assign req_ready = !rst && state_q == IDLE && !fifo_full;
  assign req_fire = req_valid && req_ready;
  assign dma_cmd_rd_en = !rst && state_q == ISSUE && os_q < OW'(MAX_OUTSTANDING);
  assign dma_cmd_rd_last = dma_cmd_rd_en && left_q == 13'd1;
  assign dma_cmd_rd_addr = addr_q;
  assign cmd_fire = dma_cmd_rd_en && dma_cmd_rd_ready;
  assign dma_rd_resp_ready = m_tready && !rst;
  assign m_tvalid = dma_rd_resp_valid && !rst;
  assign m_tdata = dma_rd_resp_data;
  assign resp_fire = dma_rd_resp_valid && dma_rd_resp_ready;
  // A response with no pending request is passed through as an empty, terminating beat.
  assign head_last = rcnt_q + 13'd1 == head.beats;
  assign m_tkeep = fifo_empty ? '0 : keep_mask(rcnt_q == '0, head_last, head.first_off, head.end_off);
  assign m_tlast = fifo_empty || head_last;
  simple_fifo #(.WIDTH($bits(meta_t)), .DEPTH(META_DEPTH)) u_meta (
    .clk(clk), .rst(rst),
    .push_i(req_fire && req_len != '0), .din_i(entry),
    .pop_i(resp_fire && head_last),
    .dout_o(head), .full_o(fifo_full), .empty_o(fifo_empty)
  );
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    left_d = left_q;
    if (req_fire && req_len != '0) begin
      state_d = ISSUE;
      addr_d = {req_addr[ADDR_WIDTH-1:4], 4'h0};
      left_d = beats;
    end
    if (cmd_fire) begin
      addr_d = addr_q + ADDR_WIDTH'(BEAT_BYTES);
      left_d = left_q - 13'd1;
      state_d = left_q == 13'd1 ? IDLE : ISSUE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      left_q <= '0;
      os_q <= '0;
      rcnt_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      left_q <= left_d;
      os_q <= os_q + OW'(cmd_fire) - OW'(resp_fire);
      rcnt_q <= (resp_fire && !fifo_empty) ? (head_last ? '0 : rcnt_q + 13'd1) : rcnt_q;
    end
  end
`ifdef CORE_DMA_RD_STATS_EN
  logic [31:0] req_cnt_q, beat_cnt_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      req_cnt_q <= '0;
      beat_cnt_q <= '0;
    end else begin
      req_cnt_q <= req_cnt_q + 32'(resp_fire && m_tlast);
      beat_cnt_q <= beat_cnt_q + 32'(resp_fire);
    end
  end
  assign stat_req_count = req_cnt_q;
  assign stat_beat_count = beat_cnt_q;
`else
  assign stat_req_count = '0;
  assign stat_beat_count = '0;
`endif
endmodule
